// File: rtl/axi_portal_initiator_pkg.sv
// rtl/axi_portal_initiator_pkg.sv - shared widths, FSM state types and error bit positions
package axi_portal_initiator_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 12;
   localparam int LEN_W  = 4;
   localparam int RESP_W = 2;
   localparam int ERR_W  = 4;

   localparam int ERR_LAST    = 0;
   localparam int ERR_ID      = 1;
   localparam int ERR_RESP    = 2;
   localparam int ERR_TIMEOUT = 3;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

endpackage

// File: rtl/axi_resp_timer.sv
// rtl/axi_resp_timer.sv - idle-cycle watchdog for a response-wait state
module axi_resp_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Leaving the wait state or seeing a response both restart the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (!run || clear)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign expire = run && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_portal_initiator.sv
// rtl/axi_portal_initiator.sv - client read/write requests turned into MAXIGP0 AXI bursts
module axi_portal_initiator
   import axi_portal_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              rreq_enq__ENA,
   output logic              rreq_enq__RDY,
   input  logic [ADDR_W-1:0] rreq_enq_addr,
   input  logic [LEN_W-1:0]  rreq_enq_len,
   input  logic [ID_W-1:0]   rreq_enq_id,
   input  logic              wreq_enq__ENA,
   output logic              wreq_enq__RDY,
   input  logic [ADDR_W-1:0] wreq_enq_addr,
   input  logic [LEN_W-1:0]  wreq_enq_len,
   input  logic [ID_W-1:0]   wreq_enq_id,
   input  logic              wdata_enq__ENA,
   output logic              wdata_enq__RDY,
   input  logic [DATA_W-1:0] wdata_enq_v,
   output logic              MAXIGP0_O_AR__ENA,
   output logic [ADDR_W-1:0] MAXIGP0_O_AR_addr,
   output logic [ID_W-1:0]   MAXIGP0_O_AR_id,
   output logic [LEN_W-1:0]  MAXIGP0_O_AR_len,
   input  logic              MAXIGP0_O_AR__RDY,
   output logic              MAXIGP0_O_AW__ENA,
   output logic [ADDR_W-1:0] MAXIGP0_O_AW_addr,
   output logic [ID_W-1:0]   MAXIGP0_O_AW_id,
   output logic [LEN_W-1:0]  MAXIGP0_O_AW_len,
   input  logic              MAXIGP0_O_AW__RDY,
   output logic              MAXIGP0_O_W__ENA,
   output logic [DATA_W-1:0] MAXIGP0_O_W_data,
   output logic [ID_W-1:0]   MAXIGP0_O_W_id,
   output logic              MAXIGP0_O_W_last,
   input  logic              MAXIGP0_O_W__RDY,
   input  logic              MAXIGP0_I_R__ENA,
   input  logic [DATA_W-1:0] MAXIGP0_I_R_data,
   input  logic [ID_W-1:0]   MAXIGP0_I_R_id,
   input  logic              MAXIGP0_I_R_last,
   input  logic [RESP_W-1:0] MAXIGP0_I_R_resp,
   output logic              MAXIGP0_I_R__RDY,
   input  logic              MAXIGP0_I_B__ENA,
   input  logic [ID_W-1:0]   MAXIGP0_I_B_id,
   input  logic [RESP_W-1:0] MAXIGP0_I_B_resp,
   output logic              MAXIGP0_I_B__RDY,
   output logic              rdata_enq__ENA,
   output logic [DATA_W-1:0] rdata_enq_v,
   output logic              rdata_enq_last,
   output logic [RESP_W-1:0] rdata_enq_resp,
   input  logic              rdata_enq__RDY,
   output logic              done_enq__ENA,
   output logic [ID_W-1:0]   done_enq_id,
   output logic [RESP_W-1:0] done_enq_resp,
   input  logic              done_enq__RDY,
   output logic [ERR_W-1:0]  err,
   input  logic              errClear
);

   r_state_t          r_state, r_next;
   w_state_t          w_state, w_next;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [ID_W-1:0]   r_id, w_id;
   logic [LEN_W-1:0]  r_len, w_len, r_cnt, w_cnt;
   logic              r_final, w_final;
   logic              r_xfer, w_xfer, b_xfer;
   logic              r_expire, w_expire;
   logic [ERR_W-1:0]  err_set;

   assign r_final = (r_cnt == r_len);
   assign w_final = (w_cnt == w_len);
   assign r_xfer  = MAXIGP0_I_R__ENA && MAXIGP0_I_R__RDY;
   assign w_xfer  = MAXIGP0_O_W__ENA && MAXIGP0_O_W__RDY;
   assign b_xfer  = MAXIGP0_I_B__ENA && MAXIGP0_I_B__RDY;

   axi_resp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) r_timer (
      .clk(CLK), .rst_n(nRST), .run(r_state == R_DATA), .clear(r_xfer), .expire(r_expire)
   );

   axi_resp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) w_timer (
      .clk(CLK), .rst_n(nRST), .run(w_state == W_RESP), .clear(b_xfer), .expire(w_expire)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (rreq_enq__ENA) r_next = R_ADDR;
         R_ADDR:  if (MAXIGP0_O_AR__RDY) r_next = R_DATA;
         R_DATA:  if ((r_xfer && r_final) || r_expire) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (wreq_enq__ENA) w_next = W_ADDR;
         W_ADDR:  if (MAXIGP0_O_AW__RDY) w_next = W_DATA;
         W_DATA:  if (w_xfer && w_final) w_next = W_RESP;
         W_RESP:  if (b_xfer || w_expire) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Handshake outputs are qualified by the owning state only, never by the same channel's ready.
   always_comb begin
      rreq_enq__RDY     = (r_state == R_IDLE);
      MAXIGP0_O_AR__ENA = (r_state == R_ADDR);
      MAXIGP0_I_R__RDY  = (r_state == R_DATA) && rdata_enq__RDY;
      rdata_enq__ENA    = (r_state == R_DATA) && MAXIGP0_I_R__ENA;
      wreq_enq__RDY     = (w_state == W_IDLE);
      MAXIGP0_O_AW__ENA = (w_state == W_ADDR);
      MAXIGP0_O_W__ENA  = (w_state == W_DATA) && wdata_enq__ENA;
      wdata_enq__RDY    = (w_state == W_DATA) && MAXIGP0_O_W__RDY;
      MAXIGP0_I_B__RDY  = (w_state == W_RESP) && done_enq__RDY;
      done_enq__ENA     = (w_state == W_RESP) && MAXIGP0_I_B__ENA;
   end

   assign MAXIGP0_O_AR_addr = r_addr;
   assign MAXIGP0_O_AR_id   = r_id;
   assign MAXIGP0_O_AR_len  = r_len;
   assign MAXIGP0_O_AW_addr = w_addr;
   assign MAXIGP0_O_AW_id   = w_id;
   assign MAXIGP0_O_AW_len  = w_len;
   assign MAXIGP0_O_W_data  = wdata_enq_v;
   assign MAXIGP0_O_W_id    = w_id;
   assign MAXIGP0_O_W_last  = w_final;
   assign rdata_enq_v       = MAXIGP0_I_R_data;
   assign rdata_enq_last    = MAXIGP0_I_R_last;
   assign rdata_enq_resp    = MAXIGP0_I_R_resp;
   assign done_enq_id       = MAXIGP0_I_B_id;
   assign done_enq_resp     = MAXIGP0_I_B_resp;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_addr <= '0;
         r_id   <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         w_addr <= '0;
         w_id   <= '0;
         w_len  <= '0;
         w_cnt  <= '0;
      end else begin
         if (rreq_enq__RDY && rreq_enq__ENA) begin
            r_addr <= rreq_enq_addr;
            r_id   <= rreq_enq_id;
            r_len  <= rreq_enq_len;
            r_cnt  <= '0;
         end else if (r_xfer) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (wreq_enq__RDY && wreq_enq__ENA) begin
            w_addr <= wreq_enq_addr;
            w_id   <= wreq_enq_id;
            w_len  <= wreq_enq_len;
            w_cnt  <= '0;
         end else if (w_xfer) begin
            w_cnt <= w_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      err_set = '0;
      if (r_xfer) begin
         if (MAXIGP0_I_R_last != r_final) err_set[ERR_LAST] = 1'b1;
         if (MAXIGP0_I_R_id != r_id) err_set[ERR_ID] = 1'b1;
         if (MAXIGP0_I_R_resp != '0) err_set[ERR_RESP] = 1'b1;
      end
      if (b_xfer) begin
         if (MAXIGP0_I_B_id != w_id) err_set[ERR_ID] = 1'b1;
         if (MAXIGP0_I_B_resp != '0) err_set[ERR_RESP] = 1'b1;
      end
      if (r_expire || w_expire) err_set[ERR_TIMEOUT] = 1'b1;
   end

   // A new error in the clearing cycle survives the clear.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         err <= '0;
      else
         err <= (errClear ? '0 : err) | err_set;
   end

endmodule
